store_controller: RTL
=====================

# store_controller

Sequences write-back of a finished output tile (C = A·B) from the systolic-array result buffer to memory, one row per beat. It sits beside the load/execute controller, which owns the shared memory interface and address generator. That controller grants access with `can_store` and forwards this block's `*_store` outputs to the interface and address generator while it is in its store phase. The block produces the row addresses and write beats, and signals `done_store` on the final row so the load/execute controller can release the interface in the same cycle.

## Interface
Parameters:
- ADDR_W, 32, address/stride width
- SIZE_W, 5, tile-dimension width (msize/nsize)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse; latches config and arms a store
- tile_C_addr  in  ADDR_W  base address of C row 0
- tile_C_stride  in  ADDR_W  byte offset between C rows (added, unsigned, wraps mod 2^ADDR_W)
- msize  in  SIZE_W  number of C rows to write
- nsize  in  SIZE_W  elements per row (beat length)
- can_store  in  1  grant from load/execute controller
- current_addr  in  ADDR_W  address currently held by address generator
- row_valid  in  1  result buffer has a complete row at its head
- row_pop  out  1  dequeue head row (same cycle as its write beat)
- gen_addr_store  out  1  load next_row_addr_store into address generator
- next_row_addr_store  out  ADDR_W  address to load
- interface_en_store  out  1  memory beat request
- interface_control_store  out  SIZE_W  beat length (= latched nsize)
- interface_rdwr_store  out  1  1 = write
- done_store  out  1  final row beat in this cycle
- busy  out  1  store armed or in progress

## Operation
- Registered state: `cs` ∈ {IDLE, ARMED, WRITE}, row counter `rcnt` (SIZE_W), latched `c_addr`, `c_stride`, `m`, `n`. All outputs are combinational (Mealy) from state, latches and inputs.
- IDLE: `start`=1 latches config, clears `rcnt`, next state ARMED. Otherwise stay.
- ARMED:
  - `can_store`=0: hold.
  - `can_store`=1, m≠0, n≠0: `gen_addr_store`=1, `next_row_addr_store`=c_addr, next state WRITE.
  - `can_store`=1, m=0 or n=0: `done_store`=1 with no beat, next state IDLE.
- WRITE, stall condition (`can_store`=0 or `row_valid`=0): all beat/gen outputs 0, hold state and `rcnt`.
- WRITE, beat condition (`can_store`=1 and `row_valid`=1):
  - Every beat: `interface_en_store`=1, `interface_rdwr_store`=1, `interface_control_store`=n, `row_pop`=1.
  - Not last (`rcnt`≠m−1): also `gen_addr_store`=1, `next_row_addr_store`=current_addr+c_stride, `rcnt`++.
  - Last (`rcnt`=m−1): `gen_addr_store`=0, `done_store`=1, next state IDLE.
- `busy`=1 in ARMED and WRITE.
- Inactive outputs: `next_row_addr_store` drives 0 when `gen_addr_store`=0; `interface_control_store` drives 0 when `interface_en_store`=0 (never X).
- `start` while busy: ignored; latches are not disturbed.
- Config inputs are sampled only on the accepted `start`.

## Timing
- Reset: next edge with `rst`=1 forces IDLE and clears `rcnt` and all latches. Every output reads 0 from that point. Reset mid-store aborts with no `done_store`.
- start → ARMED: 1 cycle. The earliest `gen_addr_store` is in the cycle after `start`.
- Address generator registers `gen_addr_store` at the edge, so `current_addr` is valid from the first WRITE cycle. This allows one row per cycle back-to-back.
- Minimum store duration with `can_store` and `row_valid` held high: 1 (start) + 1 (prime) + m cycles. `done_store` is asserted in the last of these cycles.
- `done_store` is a single-cycle pulse coincident with the final beat. The block is IDLE on the next cycle and accepts a new `start` then.
- Stalls insert whole cycles only; no beat, pop or address update occurs during a stall cycle.

## Test plan
- Basic: start with tile_C_addr=0x1000, stride=0x40, msize=4, nsize=8, can_store and row_valid held 1. Expect prime gen at 0x1000. Beats follow at 0x1000/0x1040/0x1080/0x10C0, each with control=8, rdwr=1 and pop. `done_store` is asserted on the 4th beat. Total 6 cycles from start to done.
- Backpressure: same config, with row_valid low on the cycle of beat 2 and can_store low for 2 cycles before beat 3. Expect no beat or pop on stalled cycles, addresses unchanged, 4 beats total, done after 9 cycles.
- Degenerate: msize=0, can_store=1. Expect `done_store` one cycle after start, no `interface_en_store`, no `row_pop`.
- Wrap and single row: tile_C_addr=0xFFFFFFC0, stride=0x80, msize=2. Second beat address must be 0x00000040. Then msize=1: one beat with done on it and no second gen.
- Reset mid-store: rst=1 after beat 2 of msize=5. Expect all outputs 0 from the next cycle, no done_store, and a subsequent start running cleanly from row 0.
- Start while busy: pulse start with new config during WRITE. Expect it ignored and the original m, addresses and beat count to complete unchanged.

Source files
------------

// File: rtl/store_controller.sv
// Write-back sequencer for a finished output tile: one C row per memory beat,
// with the row address chained through the shared address generator.
module store_controller #(
    parameter int ADDR_W = 32,
    parameter int SIZE_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] tile_C_addr,
    input  logic [ADDR_W-1:0] tile_C_stride,
    input  logic [SIZE_W-1:0] msize,
    input  logic [SIZE_W-1:0] nsize,
    input  logic              can_store,
    input  logic [ADDR_W-1:0] current_addr,
    input  logic              row_valid,
    output logic              row_pop,
    output logic              gen_addr_store,
    output logic [ADDR_W-1:0] next_row_addr_store,
    output logic              interface_en_store,
    output logic [SIZE_W-1:0] interface_control_store,
    output logic              interface_rdwr_store,
    output logic              done_store,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t            cs_q, cs_d;
    logic [SIZE_W-1:0] rcnt_q, rcnt_d;
    logic [ADDR_W-1:0] c_addr_q, c_addr_d;
    logic [ADDR_W-1:0] c_stride_q, c_stride_d;
    logic [SIZE_W-1:0] m_q, m_d;
    logic [SIZE_W-1:0] n_q, n_d;

    logic beat_s;
    logic last_s;
    logic empty_s;

    assign beat_s  = can_store & row_valid;
    assign last_s  = (rcnt_q == (m_q - {{(SIZE_W-1){1'b0}}, 1'b1}));
    assign empty_s = (m_q == {SIZE_W{1'b0}}) | (n_q == {SIZE_W{1'b0}});

    // State and configuration registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_q       <= IDLE;
            rcnt_q     <= {SIZE_W{1'b0}};
            c_addr_q   <= {ADDR_W{1'b0}};
            c_stride_q <= {ADDR_W{1'b0}};
            m_q        <= {SIZE_W{1'b0}};
            n_q        <= {SIZE_W{1'b0}};
        end else begin
            cs_q       <= cs_d;
            rcnt_q     <= rcnt_d;
            c_addr_q   <= c_addr_d;
            c_stride_q <= c_stride_d;
            m_q        <= m_d;
            n_q        <= n_d;
        end
    end

    // Next-state and latch update; config is only captured from IDLE
    always_comb begin
        cs_d       = cs_q;
        rcnt_d     = rcnt_q;
        c_addr_d   = c_addr_q;
        c_stride_d = c_stride_q;
        m_d        = m_q;
        n_d        = n_q;
        case (cs_q)
            IDLE: begin
                if (start) begin
                    cs_d       = ARMED;
                    rcnt_d     = {SIZE_W{1'b0}};
                    c_addr_d   = tile_C_addr;
                    c_stride_d = tile_C_stride;
                    m_d        = msize;
                    n_d        = nsize;
                end else begin
                    cs_d = IDLE;
                end
            end
            ARMED: begin
                if (can_store) begin
                    cs_d = empty_s ? IDLE : WRITE;
                end else begin
                    cs_d = ARMED;
                end
            end
            WRITE: begin
                if (beat_s && last_s) begin
                    cs_d = IDLE;
                end else if (beat_s) begin
                    rcnt_d = rcnt_q + {{(SIZE_W-1){1'b0}}, 1'b1};
                end else begin
                    cs_d = WRITE;
                end
            end
            default: begin
                cs_d = IDLE;
            end
        endcase
    end

    // Mealy outputs; inactive data fields are forced to zero
    always_comb begin
        row_pop                 = 1'b0;
        gen_addr_store          = 1'b0;
        next_row_addr_store     = {ADDR_W{1'b0}};
        interface_en_store      = 1'b0;
        interface_control_store = {SIZE_W{1'b0}};
        interface_rdwr_store    = 1'b0;
        done_store              = 1'b0;
        busy                    = 1'b0;
        case (cs_q)
            IDLE: begin
                busy = 1'b0;
            end
            ARMED: begin
                busy = 1'b1;
                if (can_store && empty_s) begin
                    done_store = 1'b1;
                end else if (can_store) begin
                    gen_addr_store      = 1'b1;
                    next_row_addr_store = c_addr_q;
                end else begin
                    done_store = 1'b0;
                end
            end
            WRITE: begin
                busy = 1'b1;
                if (beat_s) begin
                    interface_en_store      = 1'b1;
                    interface_rdwr_store    = 1'b1;
                    interface_control_store = n_q;
                    row_pop                 = 1'b1;
                    if (last_s) begin
                        done_store = 1'b1;
                    end else begin
                        gen_addr_store      = 1'b1;
                        next_row_addr_store = current_addr + c_stride_q;
                    end
                end else begin
                    row_pop = 1'b0;
                end
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule
